// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, {shift, alu_op} encodings, operand selects and decoded-payload type for the ALU-control stage.
// The md_op payload field exists only when ALU_CTRL_MULDIV_EN is defined.
package alu_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // {shift[1:0], alu_op[3:0]}
    localparam logic [5:0] ENC_AND  = 6'b000000;
    localparam logic [5:0] ENC_XOR  = 6'b000001;
    localparam logic [5:0] ENC_ADD  = 6'b000010;
    localparam logic [5:0] ENC_OR   = 6'b000011;
    localparam logic [5:0] ENC_SGEU = 6'b001101;
    localparam logic [5:0] ENC_SGE  = 6'b000101;
    localparam logic [5:0] ENC_SUB  = 6'b000110;
    localparam logic [5:0] ENC_SLT  = 6'b000111;
    localparam logic [5:0] ENC_SLTU = 6'b001111;
    localparam logic [5:0] ENC_NOR  = 6'b001100;
    localparam logic [5:0] ENC_SLL  = 6'b010000;
    localparam logic [5:0] ENC_SRL  = 6'b100000;
    localparam logic [5:0] ENC_SRA  = 6'b110000;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;
    localparam logic       SRCB_RS2  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;

    typedef struct packed {
`ifdef ALU_CTRL_MULDIV_EN
        logic [2:0] md_op;
`endif
        logic       illegal;
        logic       src_b;
        logic [1:0] src_a;
        logic [5:0] enc;
    } dec_t;

    // Register-register and register-immediate arithmetic share this funct3 map;
    // only the register form turns funct3 000 with alt into SUB.
    function automatic logic [5:0] arith_enc(input logic [2:0] f3, input logic alt, input logic sub_ok);
        logic [5:0] enc;
        case (f3)
            3'b000:  enc = (sub_ok && alt) ? ENC_SUB : ENC_ADD;
            3'b001:  enc = ENC_SLL;
            3'b010:  enc = ENC_SLT;
            3'b011:  enc = ENC_SLTU;
            3'b100:  enc = ENC_XOR;
            3'b101:  enc = alt ? ENC_SRA : ENC_SRL;
            3'b110:  enc = ENC_OR;
            default: enc = ENC_AND;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I instruction -> ALU-control payload decoder with illegal detection.
// Zero latency, no flow control; RV32M funct7 accepted only with ALU_CTRL_MULDIV_EN.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] instr,
    output dec_t            dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt;
    logic       ill;
    logic       unused_regs;

    assign opc         = instr[6:0];
    assign f3          = instr[14:12];
    assign f7          = instr[31:25];
    assign alt         = instr[30];
    assign unused_regs = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec       = '0;
        dec.enc   = ENC_AND;
        dec.src_a = SRCA_RS1;
        dec.src_b = SRCB_RS2;
        ill       = 1'b0;
        case (opc)
            OPC_OP_IMM: begin
                dec.enc   = arith_enc(f3, alt, 1'b0);
                dec.src_b = SRCB_IMM;
                if (f3 == 3'b001 && f7 != F7_BASE) ill = 1'b1;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
            end
            OPC_OP: begin
                if (f7 == F7_BASE)
                    dec.enc = arith_enc(f3, alt, 1'b1);
                else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    dec.enc = arith_enc(f3, alt, 1'b1);
`ifdef ALU_CTRL_MULDIV_EN
                else if (f7 == F7_MULDIV)
                    dec.md_op = f3;
`endif
                else
                    ill = 1'b1;
            end
            OPC_LUI: begin
                dec.enc   = ENC_ADD;
                dec.src_a = SRCA_ZERO;
                dec.src_b = SRCB_IMM;
            end
            OPC_AUIPC, OPC_JAL: begin
                dec.enc   = ENC_ADD;
                dec.src_a = SRCA_PC;
                dec.src_b = SRCB_IMM;
            end
            OPC_JALR, OPC_LOAD, OPC_STORE: begin
                dec.enc   = ENC_ADD;
                dec.src_b = SRCB_IMM;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000, 3'b001: dec.enc = ENC_SUB;
                    3'b100:         dec.enc = ENC_SLT;
                    3'b101:         dec.enc = ENC_SGE;
                    3'b110:         dec.enc = ENC_SLTU;
                    3'b111:         dec.enc = ENC_SGEU;
                    default:        ill     = 1'b1;
                endcase
            end
            OPC_MISC_MEM, OPC_SYSTEM: dec.enc = ENC_AND;
            default: ill = 1'b1;
        endcase
        // Illegal entries still travel downstream, so give them one fixed, harmless payload.
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered RV32I ALU-control decode stage (optional RV32M decode under ALU_CTRL_MULDIV_EN).
// One-cycle latency via a 2-entry skid buffer; in_ready drops only when both entries are occupied.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int ILEN        = 32,
    parameter int TAG_BITS    = 4,
    parameter int ALU_OP_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ILEN-1:0]        in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ALU_OP_BITS-1:0] out_alu_op,
    output logic [1:0]             out_shift,
    output logic [1:0]             out_src_a,
    output logic                   out_src_b,
    output logic                   out_illegal,
    output logic [TAG_BITS-1:0]    out_tag
`ifdef ALU_CTRL_MULDIV_EN
    ,
    output logic [2:0]             out_md_op
`endif
);

    if (ILEN != 32) begin : g_ilen_chk
        $error("alu_ctrl_stage: only ILEN = 32 is supported");
    end
    if (ALU_OP_BITS < 4) begin : g_aluop_chk
        $error("alu_ctrl_stage: ALU_OP_BITS must be at least 4");
    end

    typedef enum logic [1:0] {EMPTY, ONE, FULL} cnt_e;

    typedef struct packed {
        dec_t                dec;
        logic [TAG_BITS-1:0] tag;
    } entry_t;

    cnt_e                cnt_q, cnt_d;
    entry_t              head_q, tail_q, new_dat;
    dec_t                dec_dat;
    logic [TAG_BITS-1:0] tag_q;
    logic                acc_vld, drn_vld;

    alu_ctrl_decode #(.ILEN(ILEN)) u_decode (
        .instr (in_instr),
        .dec   (dec_dat)
    );

    assign new_dat   = {dec_dat, tag_q};
    assign in_ready  = rst_n && (cnt_q != FULL);
    assign out_valid = (cnt_q != EMPTY);
    assign acc_vld   = in_valid && in_ready;
    assign drn_vld   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= EMPTY;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = EMPTY;
        end else begin
            case (cnt_q)
                EMPTY:   if (acc_vld) cnt_d = ONE;
                ONE: begin
                    if (acc_vld && !drn_vld)      cnt_d = FULL;
                    else if (!acc_vld && drn_vld) cnt_d = EMPTY;
                end
                FULL:    if (drn_vld) cnt_d = ONE;
                default: cnt_d = EMPTY;
            endcase
        end
    end

    // Head always feeds the outputs; the tail only fills when head is busy and not draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            tag_q  <= '0;
        end else if (!flush) begin
            if (acc_vld) tag_q <= tag_q + TAG_BITS'(1);
            if (drn_vld)
                head_q <= (cnt_q == FULL) ? tail_q : new_dat;
            else if (acc_vld && cnt_q == EMPTY)
                head_q <= new_dat;
            if (acc_vld && !drn_vld && cnt_q == ONE)
                tail_q <= new_dat;
        end
    end

    assign out_alu_op  = ALU_OP_BITS'(head_q.dec.enc[3:0]);
    assign out_shift   = head_q.dec.enc[5:4];
    assign out_src_a   = head_q.dec.src_a;
    assign out_src_b   = head_q.dec.src_b;
    assign out_illegal = head_q.dec.illegal;
    assign out_tag     = head_q.tag;
`ifdef ALU_CTRL_MULDIV_EN
    assign out_md_op   = head_q.dec.md_op;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: decode vector table, hand-written handshake/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_alu_ctrl_stage;

    localparam int TB_TAG = 4;
`ifdef ALU_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [5:0] E_AND = 6'b000000, E_XOR = 6'b000001, E_ADD = 6'b000010, E_OR = 6'b000011;
    localparam logic [5:0] E_SGEU = 6'b001101, E_SGE = 6'b000101, E_SUB = 6'b000110, E_SLT = 6'b000111;
    localparam logic [5:0] E_SLTU = 6'b001111, E_SLL = 6'b010000, E_SRL = 6'b100000, E_SRA = 6'b110000;

    localparam logic [5:0] ARITH_TAB [8] = '{E_ADD, E_SLL, E_SLT, E_SLTU, E_XOR, E_SRL, E_OR, E_AND};
    localparam logic [5:0] BR_TAB    [8] = '{E_SUB, E_SUB, E_AND, E_AND, E_SLT, E_SGE, E_SLTU, E_SGEU};
    localparam logic [7:0] BR_OK         = 8'b1111_0011;

    localparam logic [31:0] I_ADDI = 32'h00100093, I_SUB = 32'h40000033;
    localparam logic [31:0] I_XORI = 32'h00004013, I_ORI = 32'h00006013;

    typedef struct packed {
        logic       ill;
        logic [5:0] enc;
        logic [1:0] sa;
        logic       sb;
        logic [2:0] md;
        logic [3:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic [5:0]  enc;
        logic [1:0]  sa;
        logic        sb;
    } vec_t;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_shift, out_src_a;
    logic        out_src_b, out_illegal;
    logic [TB_TAG-1:0] out_tag;
`ifdef ALU_CTRL_MULDIV_EN
    logic [2:0]  out_md_op;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   tag_ctr = 0;
    exp_t q[$];
    vec_t vt[31];

    alu_ctrl_stage #(.ILEN(32), .TAG_BITS(TB_TAG), .ALU_OP_BITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_op  (out_alu_op),
        .out_shift   (out_shift),
        .out_src_a   (out_src_a),
        .out_src_b   (out_src_b),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
`ifdef ALU_CTRL_MULDIV_EN
        ,
        .out_md_op   (out_md_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference decode written directly from the opcode/funct tables.
    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        e  = '0;
        f3 = i[14:12];
        f7 = i[31:25];
        ok = 1'b1;
        e.enc = E_ADD;
        case (i[6:0])
            7'h13: begin
                e.sb  = 1'b1;
                e.enc = (f3 == 3'd5 && i[30]) ? E_SRA : ARITH_TAB[f3];
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'h33: begin
                if (f7 == 7'h01) begin
                    ok    = MD_EN;
                    e.enc = E_AND;
                    e.md  = f3;
                end else begin
                    ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                    e.enc = (f7 == 7'h20) ? ((f3 == 3'd0) ? E_SUB : E_SRA) : ARITH_TAB[f3];
                end
            end
            7'h37:               begin e.sa = 2'b10; e.sb = 1'b1; end
            7'h17, 7'h6F:        begin e.sa = 2'b01; e.sb = 1'b1; end
            7'h67, 7'h03, 7'h23: e.sb = 1'b1;
            7'h63:               begin ok = BR_OK[f3]; e.enc = BR_TAB[f3]; end
            7'h0F, 7'h73:        e.enc = E_AND;
            default:             ok = 1'b0;
        endcase
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t dut_view();
        exp_t d;
        d.ill = out_illegal;
        d.enc = {out_shift, out_alu_op};
        d.sa  = out_src_a;
        d.sb  = out_src_b;
`ifdef ALU_CTRL_MULDIV_EN
        d.md  = out_md_op;
`else
        d.md  = 3'b000;
`endif
        d.tag = out_tag;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc, f7;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:       opc = 7'h13;
            1, 2:    opc = 7'h33;
            3:       opc = 7'h37;
            4:       opc = 7'h17;
            5:       opc = 7'h6F;
            6:       opc = 7'h67;
            7, 8:    opc = 7'h63;
            9:       opc = 7'h03;
            10:      opc = 7'h23;
            11:      opc = 7'h0F;
            12:      opc = 7'h73;
            default: opc = r[6:0];
        endcase
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = r[31:25];
        endcase
        return {f7, r[24:7], opc};
    endfunction

    // One clock of stimulus: drive, check in_ready, advance the model, check the head entry.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl, input logic rst);
        logic exp_rdy, acc, drn;
        exp_t e;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rst;
        #1;
        exp_rdy = rst && (q.size() < 2);
        chk("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        drn = ordy && (q.size() > 0);
        @(posedge clk);
        if (!rst) begin
            q.delete();
            tag_ctr = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                e     = ref_decode(ins);
                e.tag = 4'(tag_ctr % (1 << TB_TAG));
                q.push_back(e);
                tag_ctr++;
            end
        end
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) chk("head", dut_view(), q[0]);
    endtask

    initial begin
        vt[0]  = '{32'h40A5D533, 1'b0, E_SRA,  2'b00, 1'b0};
        vt[1]  = '{32'h00208063, 1'b0, E_SUB,  2'b00, 1'b0};
        vt[2]  = '{32'h00205063, 1'b0, E_SGE,  2'b00, 1'b0};
        vt[3]  = '{32'h00207063, 1'b0, E_SGEU, 2'b00, 1'b0};
        vt[4]  = '{32'h00202063, 1'b1, E_AND,  2'b00, 1'b0};
        vt[5]  = '{32'hFFFFFFFF, 1'b1, E_AND,  2'b00, 1'b0};
        vt[6]  = '{32'h02000033, !MD_EN, E_AND, 2'b00, 1'b0};
        vt[7]  = '{32'h123450B7, 1'b0, E_ADD,  2'b10, 1'b1};
        vt[8]  = '{32'h00000097, 1'b0, E_ADD,  2'b01, 1'b1};
        vt[9]  = '{32'h0000006F, 1'b0, E_ADD,  2'b01, 1'b1};
        vt[10] = '{32'h00008067, 1'b0, E_ADD,  2'b00, 1'b1};
        vt[11] = '{32'h00100093, 1'b0, E_ADD,  2'b00, 1'b1};
        vt[12] = '{32'h4010D093, 1'b0, E_SRA,  2'b00, 1'b1};
        vt[13] = '{32'h40109093, 1'b1, E_AND,  2'b00, 1'b0};
        vt[14] = '{32'h40000033, 1'b0, E_SUB,  2'b00, 1'b0};
        vt[15] = '{32'h40007033, 1'b1, E_AND,  2'b00, 1'b0};
        vt[16] = '{32'h00002003, 1'b0, E_ADD,  2'b00, 1'b1};
        vt[17] = '{32'h00002023, 1'b0, E_ADD,  2'b00, 1'b1};
        vt[18] = '{32'h0000000F, 1'b0, E_AND,  2'b00, 1'b0};
        vt[19] = '{32'h00000073, 1'b0, E_AND,  2'b00, 1'b0};
        vt[20] = '{32'h00003033, 1'b0, E_SLTU, 2'b00, 1'b0};
        vt[21] = '{32'h00000012, 1'b1, E_AND,  2'b00, 1'b0};
        vt[22] = '{32'h00004013, 1'b0, E_XOR,  2'b00, 1'b1};
        vt[23] = '{32'h00006013, 1'b0, E_OR,   2'b00, 1'b1};
        vt[24] = '{32'h00001013, 1'b0, E_SLL,  2'b00, 1'b1};
        vt[25] = '{32'h0000D033, 1'b0, E_SRL,  2'b00, 1'b0};
        vt[26] = '{32'h00002033, 1'b0, E_SLT,  2'b00, 1'b0};
        vt[27] = '{32'h00206063, 1'b0, E_SLTU, 2'b00, 1'b0};
        vt[28] = '{32'h00204063, 1'b0, E_SLT,  2'b00, 1'b0};
        vt[29] = '{32'h00203063, 1'b1, E_AND,  2'b00, 1'b0};
        vt[30] = '{32'h00000000, 1'b1, E_AND,  2'b00, 1'b0};

        // Reset state
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_payload", dut_view(), 64'd0);

        // Decode table, one instruction per cycle with execute always ready
        for (int k = 0; k < 31; k++) begin
            step(1'b1, vt[k].instr, 1'b1, 1'b0, 1'b1);
            chk($sformatf("vec%0d", k), {out_illegal, out_shift, out_alu_op, out_src_a, out_src_b},
                {vt[k].ill, vt[k].enc, vt[k].sa, vt[k].sb});
            if (k == 0) chk("first_tag", out_tag, 0);
        end

        // Back-pressure: two accepts fill the buffer, third is held off and not lost
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, I_ADDI, 1'b0, 1'b0, 1'b1);
        step(1'b1, I_SUB,  1'b0, 1'b0, 1'b1);
        chk("bp_full_rdy", in_ready, 0);
        step(1'b1, I_XORI, 1'b0, 1'b0, 1'b1);
        chk("bp_tag0", out_tag, 0);
        step(1'b1, I_XORI, 1'b1, 1'b0, 1'b1);
        chk("bp_tag1", out_tag, 1);
        step(1'b1, I_XORI, 1'b1, 1'b0, 1'b1);
        chk("bp_tag2", out_tag, 2);
        chk("bp_op2", {out_shift, out_alu_op}, E_XOR);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("bp_empty", out_valid, 0);

        // Flush while full, then flush swallowing a simultaneous accept
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, I_ADDI, 1'b0, 1'b0, 1'b1);
        step(1'b1, I_SUB,  1'b0, 1'b0, 1'b1);
        step(1'b1, I_XORI, 1'b0, 1'b1, 1'b1);
        chk("flush_full_vld", out_valid, 0);
        step(1'b1, I_ORI,  1'b0, 1'b0, 1'b1);
        step(1'b1, I_XORI, 1'b0, 1'b1, 1'b1);
        chk("flush_acc_vld", out_valid, 0);
        step(1'b1, I_ADDI, 1'b1, 1'b0, 1'b1);
        chk("flush_next_tag", out_tag, 3);

        // Tag wrap over 17 accepts, then reset mid-stream restarts the tag
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            step(1'b1, I_ADDI, 1'b1, 1'b0, 1'b1);
            chk($sformatf("wrap_tag%0d", k), out_tag, k % 16);
        end
        step(1'b1, I_ADDI, 1'b1, 1'b0, 1'b0);
        chk("midrst_vld", out_valid, 0);
        step(1'b1, I_ADDI, 1'b1, 1'b0, 1'b1);
        chk("midrst_tag", out_tag, 0);

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 15) == 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
